maze_route_sched: RTL
=====================

// Module: maze_route_sched
// PURPOSE
//  Round-robin scheduler that shares the 8-room maze walker between NUM_REQ requesters.
//  Each requester supplies a target room.
//  The block drives the walker's move input every cycle along the shortest path to the
//  granted target, and pulses done on arrival.
//  When idle it steers the walker to a self-loop park room and holds it there.
//  It also checks the room reported by the walker against its own model.
// PARAMETERS
//  NUM_REQ    4  number of requesters (2..8)
//  PARK_ROOM  0  idle holding room; must be 0, 3 or 6 (self-loop rooms); elaboration error otherwise
//  MAX_HOPS   6  hops allowed per trip before abort (shortest path is always <=5)
// PORTS
//  clk       in   1          clock, rising edge
//  rst       in   1          asynchronous, active-high reset
//  req       in   NUM_REQ    level request, one bit per requester
//  tgt_room  in   3*NUM_REQ  target room of requester i at [3i+2:3i]
//  gnt       out  NUM_REQ    one-hot grant; held for the whole trip
//  done      out  1          1-cycle arrival pulse; gnt is valid in the same cycle
//  timeout   out  1          1-cycle abort pulse; gnt is valid in the same cycle
//  busy      out  1          high while in NAV
//  room_in   in   3          current room from the walker (its registered state)
//  move      out  1          walker move input; sampled by the walker at every clk edge
//  sync_err  out  1          sticky flag: room_in differs from predicted room
// BEHAVIOUR
//  - Reset values: gnt=0, done=0, timeout=0, busy=0, sync_err=0, state=IDLE,
//    rr_ptr=0, hop_cnt=0, pred_room=0. The walker resets to room0 on the same rst.
//  - The walker moves on every edge, so move is always significant:
//    move = NAV_MOVE[room_in][steer].
//    steer = cur_tgt in NAV while room_in != cur_tgt; otherwise PARK_ROOM.
//  - NAV_MOVE[r][t] is the first move on a shortest path r->t, ties broken to 0.
//    For r == t it is the self-loop bit (room0:0, room3:0, room6:1).
//  - move depends only on room_in and registered state; there is no comb path from req or tgt_room.
//  - State IDLE:
//    - If req != 0, the round-robin pick is granted: priority starts at rr_ptr.
//    - At the next edge: state goes to NAV, gnt is set, cur_tgt is latched, hop_cnt=0,
//      rr_ptr = granted index + 1 (mod NUM_REQ).
//  - State NAV, arrival (room_in == cur_tgt): done=1 combinationally.
//    At the next edge: state goes to IDLE and gnt is cleared.
//  - State NAV, no arrival: hop_cnt increments each cycle.
//    If hop_cnt == MAX_HOPS: timeout=1, then the same exit as arrival.
//  - Target equal to the current room: done in the first NAV cycle, 0 hops.
//  - Changes to req or tgt_room of the granted requester during NAV are ignored.
//  - A req still high after done is re-arbitrated normally; rr_ptr guarantees fairness.
//  - Back-to-back trips take at least 1 IDLE cycle between them.
//    During that IDLE cycle, move steers toward PARK_ROOM.
//  - Model check: each edge sets pred_room = NEXT_ROOM[room_in][move].
//    sync_err sets when room_in != pred_room. It clears only on rst.
//    Trips still complete or time out normally.
//  - rst mid-trip: immediate return to IDLE. No done/timeout pulse. gnt=0 asynchronously.
// STRUCTURE
//  - maze_pkg holds:
//    - room_t (3-bit enum room0..room7).
//    - NEXT_ROOM[8][2]: walker transition table.
//      r0:0->0,1->1  r1:2,4  r2:3,4  r3:3,0  r4:7,5  r5:3,6  r6:7,6  r7:1,5.
//    - NAV_MOVE[8][8]: move table, generated offline and checked in.
//    - is_park_room() function.
//  - Sub-module rr_arbiter: NUM_REQ-wide round-robin picker; inputs req and ptr,
//    outputs one-hot pick and index.
//  - Top level: FSM, hop counter, predictor and move lookup.
// TESTING (bench instantiates the real walker on the same clk/rst)
//  1. req=0001, tgt0=6 from reset: gnt=0001, move=1,1,1,1;
//     rooms 0->1->4->5->6; done in 5th NAV cycle; busy low the next cycle.
//  2. req=0001, tgt0=3 from room0: move=1,0,0, rooms 0->1->2->3; done in 4th NAV cycle.
//  3. tgt=current room (room0): done in 1st NAV cycle, move=0, room stays 0.
//  4. req=1011 held, all tgt=5: grant order 0,1,3,0; each gnt one-hot; 1 IDLE cycle between trips.
//  5. Force room_in stuck at 2 with tgt=6: sync_err=1 from the 2nd NAV cycle;
//     timeout pulse when hop_cnt=6; gnt released.
//  6. rst mid-trip (room4, tgt 6): gnt=0 and busy=0 immediately; room0 after reset;
//     no done; sync_err=0.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared walker description: room encoding, walker transition table and the
// precomputed shortest-path steering table used by the route scheduler.
package maze_pkg;

    typedef enum logic [2:0] {
        room0, room1, room2, room3, room4, room5, room6, room7
    } room_t;

    typedef enum logic {
        IDLE,
        NAV
    } state_t;

    // NEXT_ROOM[room][move]
    localparam logic [2:0] NEXT_ROOM [8][2] = '{
        '{3'd0, 3'd1},
        '{3'd2, 3'd4},
        '{3'd3, 3'd4},
        '{3'd3, 3'd0},
        '{3'd7, 3'd5},
        '{3'd3, 3'd6},
        '{3'd7, 3'd6},
        '{3'd1, 3'd5}
    };

    // NAV_MOVE[room][target]: first move of a shortest path, ties to 0;
    // the diagonal of the self-loop rooms holds their stay-put move.
    localparam logic [7:0] NAV_MOVE [8] = '{
        8'hFE, 8'hF0, 8'hF0, 8'hF7, 8'h69, 8'hC0, 8'h40, 8'h69
    };

    function automatic logic is_park_room(input int r);
        return (r == 0) || (r == 3) || (r == 6);
    endfunction

endpackage

// File: rtl/maze_route_sched_rr_arbiter.sv
// Round-robin picker: the lowest requesting index at or after ptr (wrapping)
// wins; returns both the one-hot pick and its binary index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] idx
);

    logic [N-1:0]  req_rot;
    logic [IW-1:0] off;
    logic [IW:0]   idx_raw;

    // req_rot[k] is the request k positions after ptr
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        logic [IW:0]   raw;
        logic [IW-1:0] ri;
        assign raw = {1'b0, ptr} + (IW+1)'(gi);
        assign ri  = (raw >= (IW+1)'(N)) ? IW'(raw - (IW+1)'(N)) : IW'(raw);
        assign req_rot[gi] = req[ri];
    end

    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = IW'(i);
            end
        end
    end

    assign idx_raw = {1'b0, ptr} + {1'b0, off};
    assign idx     = (idx_raw >= (IW+1)'(N)) ? IW'(idx_raw - (IW+1)'(N)) : IW'(idx_raw);

    for (genvar gi = 0; gi < N; gi++) begin : g_pick
        assign pick[gi] = (|req) && (idx == IW'(gi));
    end

endmodule

// File: rtl/maze_route_sched.sv
// Shares the maze walker between requesters: grants one trip at a time,
// steers the walker along the shortest path and parks it when idle.
module maze_route_sched
    import maze_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int PARK_ROOM = 0,
    parameter int MAX_HOPS  = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   tgt_room,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   done,
    output logic                   timeout,
    output logic                   busy,
    input  logic [2:0]             room_in,
    output logic                   move,
    output logic                   sync_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = $clog2(MAX_HOPS + 1);
    localparam logic [2:0] PARK = 3'(PARK_ROOM);

    if (!is_park_room(PARK_ROOM)) begin : g_bad_park
        $error("PARK_ROOM must be a self-loop room (0, 3 or 6)");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    room_t                cur_tgt_q, cur_tgt_d;
    logic [HW-1:0]        hop_cnt_q, hop_cnt_d;
    room_t                pred_room_q, pred_room_d;
    logic                 sync_err_q, sync_err_d;

    logic [NUM_REQ-1:0]   pick;
    logic [IW-1:0]        pick_idx;
    logic [2:0]           tgt_arr [NUM_REQ];
    logic                 arrive;
    logic                 hop_limit;
    logic [2:0]           steer;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_tgt
        assign tgt_arr[gi] = tgt_room[3*gi +: 3];
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req  (req),
        .ptr  (rr_ptr_q),
        .pick (pick),
        .idx  (pick_idx)
    );

    // move is a function of room_in and registered state only
    assign arrive    = (state_q == NAV) && (room_in == cur_tgt_q);
    assign hop_limit = (state_q == NAV) && !arrive && (hop_cnt_q == HW'(MAX_HOPS));
    assign steer     = ((state_q == NAV) && !arrive) ? cur_tgt_q : PARK;
    assign move      = NAV_MOVE[room_in][steer];

    assign gnt      = gnt_q;
    assign done     = arrive;
    assign timeout  = hop_limit;
    assign busy     = (state_q == NAV);
    assign sync_err = sync_err_q;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        cur_tgt_d   = cur_tgt_q;
        hop_cnt_d   = hop_cnt_q;
        pred_room_d = room_t'(NEXT_ROOM[room_in][move]);
        sync_err_d  = sync_err_q | (room_in != pred_room_q);

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d   = NAV;
                    gnt_d     = pick;
                    cur_tgt_d = room_t'(tgt_arr[pick_idx]);
                    hop_cnt_d = '0;
                    rr_ptr_d  = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
                end
            end
            NAV: begin
                if (arrive || hop_limit) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else begin
                    hop_cnt_d = hop_cnt_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rr_ptr_q    <= '0;
            cur_tgt_q   <= room0;
            hop_cnt_q   <= '0;
            pred_room_q <= room0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_tgt_q   <= cur_tgt_d;
            hop_cnt_q   <= hop_cnt_d;
            pred_room_q <= pred_room_d;
            sync_err_q  <= sync_err_d;
        end
    end

endmodule
